// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared ALU widths, op codes, flag indices and sequencer states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int OP_W   = 3;
  localparam int AMT_W  = 2;
  localparam int DATA_W = 8;
  localparam int FLAG_W = 4;
  localparam int WAIT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [OP_W-1:0] OP_SRL = 3'd6;
  localparam logic [OP_W-1:0] OP_ROL = 3'd7;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } seq_state_e;

  // Wrapping step through the valid op codes 0..max_op.
  function automatic logic [OP_W-1:0] step_op(
    input logic [OP_W-1:0] cur,
    input logic            up,
    input logic [OP_W-1:0] max_op
  );
    if (up) begin
      return (cur == max_op) ? '0 : cur + 1'b1;
    end
    return (cur == '0) ? max_op : cur - 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Purpose : 2-flop synchroniser, debounce counter and rising-edge press pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module  : alu_op_sequencer
// Purpose : Button front end for the 8-bit ALU: op/shift select and execute FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int NUM_OPS    = 8,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_u,
  input  logic              btn_d,
  input  logic              btn_r,
  input  logic              btn_l,
  input  logic              btn_c,
  input  logic [15:0]       sw_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [FLAG_W-1:0] alu_flags_in,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [OP_W-1:0]   alu_control,
  output logic [AMT_W-1:0]  cantidad,
  output logic [DATA_W-1:0] result_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              result_valid,
  output logic              busy
);

  localparam int NUM_BTN = 5;
  localparam int BTN_U   = 0;
  localparam int BTN_D   = 1;
  localparam int BTN_R   = 2;
  localparam int BTN_L   = 3;
  localparam int BTN_C   = 4;

  localparam logic [OP_W-1:0]   OP_MAX    = OP_W'(NUM_OPS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ALU_LAT - 1);

  logic [NUM_BTN-1:0] raw_w, level_w, press_w;

  assign raw_w = {btn_c, btn_l, btn_r, btn_d, btn_u};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_w[i]),
      .level(level_w[i]),
      .press(press_w[i])
    );
  end

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]   ctl_q, ctl_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] flg_q, flg_d;

  // Select updates and the operand latch share the IDLE edge, so a coincident
  // execute uses the freshly stepped select.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    ctl_d      = ctl_q;
    amt_d      = amt_q;
    res_d      = res_q;
    flg_d      = flg_q;
    case (state_q)
      S_IDLE: begin
        if (press_w[BTN_U] != press_w[BTN_D]) begin
          ctl_d = step_op(ctl_q, press_w[BTN_U], OP_MAX);
        end
        if (press_w[BTN_R] != press_w[BTN_L]) begin
          amt_d = press_w[BTN_R] ? amt_q + 1'b1 : amt_q - 1'b1;
        end
        if (press_w[BTN_C]) begin
          op_a_d     = sw_in[DATA_W-1:0];
          op_b_d     = sw_in[2*DATA_W-1:DATA_W];
          wait_cnt_d = WAIT_INIT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          res_d   = alu_result_in;
          flg_d   = alu_flags_in;
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      ctl_q      <= '0;
      amt_q      <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      ctl_q      <= ctl_d;
      amt_q      <= amt_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

  assign operand_a    = op_a_q;
  assign operand_b    = op_b_q;
  assign alu_control  = ctl_q;
  assign cantidad     = amt_q;
  assign result_out   = res_q;
  assign flags_out    = flg_q;
  assign result_valid = (state_q == S_CAPTURE);
  assign busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire
